// File: rtl/float_to_fixed_pipe.sv
// float_to_fixed_pipe: three-stage IEEE-754 single-precision to signed
// Q(FIXED_WIDTH-FRAC_BITS).FRAC_BITS converter.
// Stages: S1 decode, S2 align/round, S3 sign/saturate (output registers).
// A single global advance enable stalls all stages together. Bubbles stay in
// place as valid = 0.
module float_to_fixed_pipe #(
  parameter int FIXED_WIDTH = 16,
  parameter int FRAC_BITS   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_data,
  input  logic                   in_round,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FIXED_WIDTH-1:0] out_data,
  output logic                   out_ovf,
  output logic                   out_nan,
  output logic                   out_inexact
);

  // Shift that takes the 24-bit significand to the output scale:
  // sh = e - 127 + FRAC_BITS - 23.
  localparam int SH_OFF = FRAC_BITS - 150;

  localparam logic [32:0] POS_LIM = 33'((64'd1 << (FIXED_WIDTH - 1)) - 64'd1);
  localparam logic [32:0] NEG_LIM = 33'(64'd1 << (FIXED_WIDTH - 1));
  localparam logic [FIXED_WIDTH-1:0] MAX_POS = {1'b0, {(FIXED_WIDTH-1){1'b1}}};
  localparam logic [FIXED_WIDTH-1:0] MAX_NEG = {1'b1, {(FIXED_WIDTH-1){1'b0}}};

  // Decoded sample held in S1.
  typedef struct packed {
    logic        sign;
    logic        zero;    // zero or denormal: magnitude forced to 0
    logic        denorm;  // flushed denormal, reported as inexact
    logic        inf;
    logic        nan;
    logic        rnd;     // 1 = round to nearest even, 0 = truncate
    logic [9:0]  sh;      // signed shift amount (two's complement)
    logic [23:0] sig;     // significand with hidden one
  } s1_t;

  // Aligned and rounded magnitude held in S2.
  typedef struct packed {
    logic        sign;
    logic        nan;
    logic        inf;
    logic        big;     // set bits were shifted past the 33-bit window
    logic [32:0] mag;
    logic        inexact;
  } s2_t;

  logic advance;
  logic s1_valid, s2_valid;
  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;

  logic [32:0]            mag_c;
  logic                   guard_c, sticky_c, big_c, inc_c;
  logic [47:0]            wide_c;
  logic [9:0]             nsh_c;
  logic                   pos_ovf, neg_ovf;
  logic [FIXED_WIDTH-1:0] mag_lo;
  logic [FIXED_WIDTH-1:0] s3_data;
  logic                   s3_ovf, s3_nan, s3_inexact;

  // The whole pipe moves when the output slot is empty or being drained.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // S1 decode of the incoming float.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned and infer a latch.
    s1_d        = '0;
    s1_d.sign   = in_data[31];
    s1_d.zero   = (in_data[30:23] == 8'h00);
    s1_d.denorm = (in_data[30:23] == 8'h00) && (in_data[22:0] != 23'd0);
    s1_d.inf    = (in_data[30:23] == 8'hFF) && (in_data[22:0] == 23'd0);
    s1_d.nan    = (in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0);
    s1_d.rnd    = in_round;
    s1_d.sh     = 10'(int'(in_data[30:23]) + SH_OFF);
    s1_d.sig    = {1'b1, in_data[22:0]};
  end

  // S2 alignment into a 33-bit window, guard/sticky extraction and rounding.
  always_comb begin
    mag_c    = '0;
    guard_c  = 1'b0;
    sticky_c = 1'b0;
    big_c    = 1'b0;
    wide_c   = '0;
    nsh_c    = '0;
    if (s1_q.zero) begin
      sticky_c = s1_q.denorm;
    end else if (!(s1_q.inf || s1_q.nan)) begin
      if (!s1_q.sh[9]) begin
        // Left shift: the significand top bit lands at 23+sh; past bit 32 the
        // magnitude cannot fit any legal output, so flag it instead of wrapping.
        if (s1_q.sh > 10'd9) big_c = 1'b1;
        else                 mag_c = 33'(s1_q.sig) << s1_q.sh[3:0];
      end else begin
        nsh_c = -s1_q.sh;
        if (nsh_c >= 10'd25) begin
          // Everything, including the first discarded bit position, is gone.
          sticky_c = |s1_q.sig;
        end else begin
          wide_c   = {s1_q.sig, 24'd0} >> nsh_c[4:0];
          mag_c    = 33'(wide_c[47:24]);
          guard_c  = wide_c[23];
          sticky_c = |wide_c[22:0];
        end
      end
    end
    inc_c          = s1_q.rnd && guard_c && (sticky_c || mag_c[0]);
    s2_d.sign      = s1_q.sign;
    s2_d.nan       = s1_q.nan;
    s2_d.inf       = s1_q.inf;
    s2_d.big       = big_c;
    s2_d.mag       = mag_c + 33'(inc_c);
    s2_d.inexact   = guard_c || sticky_c;
  end

  // S3 sign application and saturation.
  always_comb begin
    pos_ovf    = !s2_q.sign && (s2_q.inf || s2_q.big || (s2_q.mag > POS_LIM));
    neg_ovf    =  s2_q.sign && (s2_q.inf || s2_q.big || (s2_q.mag > NEG_LIM));
    mag_lo     = s2_q.mag[FIXED_WIDTH-1:0];
    s3_data    = s2_q.sign ? -mag_lo : mag_lo;
    s3_ovf     = 1'b0;
    s3_nan     = 1'b0;
    s3_inexact = s2_q.inexact;
    if (s2_q.nan) begin
      s3_data    = '0;
      s3_nan     = 1'b1;
      s3_inexact = 1'b0;
    end else if (pos_ovf) begin
      s3_data    = MAX_POS;
      s3_ovf     = 1'b1;
      s3_inexact = 1'b1;
    end else if (neg_ovf) begin
      s3_data    = MAX_NEG;
      s3_ovf     = 1'b1;
      s3_inexact = 1'b1;
    end
  end

  // Stage valid bits: cleared by reset, shifted on advance.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
    end
  end

  // Internal payload registers, loaded only when a real sample moves in.
  always_ff @(posedge clk) begin
    // NOTE: payload is not reset; its valid bit already qualifies it, which
    // keeps the reset network on the control bits only.
    if (advance && in_valid) s1_q <= s1_d;
    if (advance && s1_valid) s2_q <= s2_d;
  end

  // Output registers: cleared by reset, updated when a sample enters S3.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data    <= '0;
      out_ovf     <= 1'b0;
      out_nan     <= 1'b0;
      out_inexact <= 1'b0;
    end else if (advance && s2_valid) begin
      out_data    <= s3_data;
      out_ovf     <= s3_ovf;
      out_nan     <= s3_nan;
      out_inexact <= s3_inexact;
    end
  end

endmodule

// File: tb/tb_float_to_fixed_pipe.sv
// Directed bench for float_to_fixed_pipe (FIXED_WIDTH = 16, FRAC_BITS = 8):
// conversion table with latency checks, a backpressure stream, and a
// mid-stream reset sequence.
module tb_float_to_fixed_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_round;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_ovf;
  logic        out_nan;
  logic        out_inexact;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] din;
    logic        rnd;
    logic [15:0] data;
    logic        ovf;
    logic        nan;
    logic        inex;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs[NVEC];

  float_to_fixed_pipe #(.FIXED_WIDTH(16), .FRAC_BITS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_round    (in_round),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_ovf     (out_ovf),
    .out_nan     (out_nan),
    .out_inexact (out_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Send one vector with out_ready high and check result and latency.
  task automatic run_vec(input int i);
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = vecs[i].din;
    in_round  = vecs[i].rnd;
    #1;
    check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
    check($sformatf("v%0d_data", i), 32'(out_data), 32'(vecs[i].data));
    check($sformatf("v%0d_ovf", i), 32'(out_ovf), 32'(vecs[i].ovf));
    check($sformatf("v%0d_nan", i), 32'(out_nan), 32'(vecs[i].nan));
    check($sformatf("v%0d_inexact", i), 32'(out_inexact), 32'(vecs[i].inex));
  endtask

  initial begin
    int q[$];
    int sent, got, idx;
    logic pend, stalled_prev;
    logic [15:0] held;

    //              din           rnd   data      ovf   nan   inex
    vecs[0]  = '{32'h3FC00000, 1'b0, 16'h0180, 1'b0, 1'b0, 1'b0}; // 1.5
    vecs[1]  = '{32'hC0300000, 1'b1, 16'hFD40, 1'b0, 1'b0, 1'b0}; // -2.75
    vecs[2]  = '{32'h3F804000, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1}; // 256.5 trunc
    vecs[3]  = '{32'h3F804000, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b1}; // 256.5 tie->even
    vecs[4]  = '{32'h3F80C000, 1'b0, 16'h0101, 1'b0, 1'b0, 1'b1}; // 257.5 trunc
    vecs[5]  = '{32'h3F80C000, 1'b1, 16'h0102, 1'b0, 1'b0, 1'b1}; // 257.5 tie->even
    vecs[6]  = '{32'h43480000, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b1}; // 200.0
    vecs[7]  = '{32'hC3000000, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b0}; // -128.0 exact
    vecs[8]  = '{32'hC3010000, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1}; // -129.0
    vecs[9]  = '{32'h7F800000, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b1}; // +inf
    vecs[10] = '{32'hFF800000, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b1}; // -inf
    vecs[11] = '{32'h7FC00000, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0}; // NaN
    vecs[12] = '{32'h80000000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0}; // -0
    vecs[13] = '{32'h00000001, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1}; // denormal
    vecs[14] = '{32'h3F800000, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0}; // 1.0
    vecs[15] = '{32'h3B400000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1}; // 0.75 lsb, round up
    vecs[16] = '{32'hBB400000, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1}; // -0.75 lsb, round
    vecs[17] = '{32'hBB400000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}; // -0.75 lsb, trunc to 0
    vecs[18] = '{32'h42FFFE00, 1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b0}; // exact max positive
    vecs[19] = '{32'h42FFFF00, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1}; // 32767.5 trunc
    vecs[20] = '{32'h42FFFF00, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b1}; // round carries to ovf
    vecs[21] = '{32'h4F000000, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b1}; // 2^31, outside window
    vecs[22] = '{32'h30000000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1}; // tiny, shift >= 25
    vecs[23] = '{32'h00000000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0}; // +0

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_round  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_flags", 32'({out_ovf, out_nan, out_inexact}), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < NVEC; i++) run_vec(i);

    // Backpressure stream: 8 samples, out_ready low for cycles 6..10.
    sent = 0;
    got = 0;
    pend = 1'b0;
    stalled_prev = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
      @(negedge clk);
      if (stalled_prev) begin
        check("stall_hold_valid", 32'(out_valid), 32'd1);
        check("stall_hold_data", 32'(out_data), 32'(held));
      end
      out_ready = !(cyc >= 6 && cyc < 11);
      if (!pend && sent < 8 && (sent < 3 || $urandom_range(0, 2) != 0)) begin
        pend     = 1'b1;
        in_data  = vecs[sent].din;
        in_round = vecs[sent].rnd;
      end
      in_valid = pend;
      #1;
      stalled_prev = out_valid && !out_ready;
      if (stalled_prev) begin
        held = out_data;
        check("stall_in_ready", 32'(in_ready), 32'd0);
      end
      if (out_valid && out_ready) begin
        check("stream_not_extra", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          idx = q.pop_front();
          check($sformatf("stream_data_%0d", idx), 32'(out_data), 32'(vecs[idx].data));
          check($sformatf("stream_ovf_%0d", idx), 32'(out_ovf), 32'(vecs[idx].ovf));
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(sent);
        sent++;
        pend = 1'b0;
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_count", 32'(got), 32'd8);
    check("stream_queue_empty", 32'(q.size()), 32'd0);
    repeat (4) @(negedge clk);

    // Reset with three samples in flight and the output stalled.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = vecs[6 + i].din;
      in_round = vecs[6 + i].rnd;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_out_data", 32'(out_data), 32'd0);
    check("midreset_flags", 32'({out_ovf, out_nan, out_inexact}), 32'd0);
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("midreset_no_stale_%0d", c), 32'(out_valid), 32'd0);
    end
    run_vec(1);
    run_vec(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
